// File: rtl/gate_selftest_seq_pkg.sv
// Shared constants and the golden truth table for the 2-input gate block self-test.
package gate_selftest_pkg;

    localparam int LED_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int LED_AND  = 0;
    localparam int LED_OR   = 1;
    localparam int LED_NAND = 2;
    localparam int LED_NOR  = 3;
    localparam int LED_XOR  = 4;

    typedef logic [1:0] vec_idx_t;

    function automatic logic [LED_W-1:0] golden_led(input logic a, input logic b);
        logic [LED_W-1:0] led;
        led           = '0;
        led[LED_AND]  = a & b;
        led[LED_OR]   = a | b;
        led[LED_NAND] = ~(a & b);
        led[LED_NOR]  = ~(a | b);
        led[LED_XOR]  = a ^ b;
        return led;
    endfunction

endpackage

// File: rtl/gate_selftest_seq_if.sv
// Bundle between the start/abort control logic, the gate block and the self-test sequencer.
interface gate_selftest_seq_if
    import gate_selftest_pkg::*;
();
    logic             i_start;
    logic             i_abort;
    logic [LED_W-1:0] i_led;
    logic             o_a;
    logic             o_b;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic [LED_W-1:0] o_fail_mask;
    vec_idx_t         o_first_fail_vec;

    // slave is the sequencer; master is the surrounding control plus gate block
    modport slave (
        input  i_start, i_abort, i_led,
        output o_a, o_b, o_busy, o_done, o_pass, o_fail_mask, o_first_fail_vec
    );
    modport master (
        output i_start, i_abort, i_led,
        input  o_a, o_b, o_busy, o_done, o_pass, o_fail_mask, o_first_fail_vec
    );
endinterface

// File: rtl/gate_selftest_seq_golden.sv
// Combinational golden model of the gate block; reusable wherever expected leds are needed.
module gate_golden
    import gate_selftest_pkg::*;
(
    input  logic             a,
    input  logic             b,
    output logic [LED_W-1:0] led
);
    assign led = golden_led(a, b);
endmodule

// File: rtl/gate_selftest_seq.sv
// Self-test sequencer: walks {a,b} through 00,01,10,11, holds each vector, then compares
// the gate block leds with the golden model and accumulates a per-led failure mask.
module gate_selftest_seq
    import gate_selftest_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    gate_selftest_seq_if.slave bus
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0]       r_state, w_state_next;
    vec_idx_t         r_k, w_k_next;
    logic [7:0]       r_cnt, w_cnt_next;
    logic [LED_W-1:0] r_fail_mask, w_fail_mask_next;
    vec_idx_t         r_first, w_first_next;
    logic             r_a, r_b, r_busy, r_done, r_pass;
    logic [LED_W-1:0] w_golden;
    logic [LED_W-1:0] w_miss;
    logic             w_busy_next;

    gate_golden u_golden (
        .a   (r_k[1]),
        .b   (r_k[0]),
        .led (w_golden)
    );

    assign w_miss = bus.i_led ^ w_golden;

    always_comb begin
        w_state_next     = r_state;
        w_k_next         = r_k;
        w_cnt_next       = r_cnt;
        w_fail_mask_next = r_fail_mask;
        w_first_next     = r_first;
        if (bus.i_abort) begin
            w_state_next     = ST_IDLE;
            w_k_next         = '0;
            w_cnt_next       = '0;
            w_fail_mask_next = '0;
            w_first_next     = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start) begin
                        w_state_next     = ST_DRIVE;
                        w_k_next         = '0;
                        w_cnt_next       = '0;
                        w_fail_mask_next = '0;
                        w_first_next     = '0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_next = ST_SAMPLE;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    w_fail_mask_next = r_fail_mask | w_miss;
                    // an empty mask means no earlier vector has failed yet
                    if ((w_miss != '0) && (r_fail_mask == '0)) begin
                        w_first_next = r_k;
                    end
                    if (r_k == 2'd3) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_k_next     = r_k + 2'd1;
                        w_cnt_next   = '0;
                        w_state_next = ST_DRIVE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_busy_next = (w_state_next == ST_DRIVE) || (w_state_next == ST_SAMPLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_cnt       <= '0;
            r_fail_mask <= '0;
            r_first     <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_k         <= w_k_next;
            r_cnt       <= w_cnt_next;
            r_fail_mask <= w_fail_mask_next;
            r_first     <= w_first_next;
            r_a         <= w_busy_next & w_k_next[1];
            r_b         <= w_busy_next & w_k_next[0];
            r_busy      <= w_busy_next;
            r_done      <= (w_state_next == ST_DONE);
            r_pass      <= (w_state_next == ST_DONE) && (w_fail_mask_next == '0);
        end
    end

    assign bus.o_a              = r_a;
    assign bus.o_b              = r_b;
    assign bus.o_busy           = r_busy;
    assign bus.o_done           = r_done;
    assign bus.o_pass           = r_pass;
    assign bus.o_fail_mask      = r_fail_mask;
    assign bus.o_first_fail_vec = r_first;

endmodule
